axi4lite_regbus_bridge: RTL and testbench
=========================================

AXI4LITE_REGBUS_BRIDGE -- requirements
Module: axi4lite_regbus_bridge

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, byte-address width of both buses.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width (32 or 64).
REQ-003 SHALL have parameter NUM_REGS, default 16, count of decoded words; word index >= NUM_REGS is out-of-range.
REQ-004 SHALL have parameter RD_LATENCY, default 1, legal 1..4, cycles from rd pulse to rdData valid.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports in order below, clock and reset first.
REQ-006 S_AXI_ACLK  in  1  sole clock, all state on rising edge.
REQ-007 S_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-008 S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  ADDR/1/1  write-address channel.
REQ-009 S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA/DATA/8/1/1  write-data channel.
REQ-010 S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write-response channel.
REQ-011 S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  ADDR/1/1  read-address channel.
REQ-012 S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA/2/1/1  read-data channel.
REQ-013 wrAddr/wrData/wrStrb/wr  out  ADDR/DATA/DATA/8/1  simple-bus write, wr one-cycle strobe.
REQ-014 rdAddr/rd  out  ADDR/1  simple-bus read request, rd one-cycle strobe.
REQ-015 rdData  in  DATA  read data, valid exactly RD_LATENCY cycles after the rd cycle.

Function
REQ-016 Write and read paths SHALL be independent FSMs; wr and rd MAY pulse in the same cycle.
REQ-017 Write FSM states SHALL be W_COLLECT, W_STROBE, W_RESP.
REQ-018 In W_COLLECT: AWREADY=1 while no address held, WREADY=1 while no data held; AW and W accepted in either order or same cycle, each latched on handshake.
REQ-019 When both held, SHALL go to W_STROBE next cycle; AWREADY=WREADY=0 from then until return to W_COLLECT.
REQ-020 W_STROBE (one cycle): in-range -> wr=1 with latched wrAddr/wrData/wrStrb; out-of-range -> wr=0; then W_RESP.
REQ-021 W_RESP: BVALID=1, BRESP=2'b00 in-range or 2'b10 out-of-range, held stable until BREADY=1, then W_COLLECT.
REQ-022 BVALID SHALL rise no earlier than 2 cycles after the later of AW/W handshake; BREADY already high -> back-to-back writes every 3 cycles.
REQ-023 Read FSM states SHALL be R_IDLE, R_ISSUE, R_WAIT, R_RESP.
REQ-024 R_IDLE: ARREADY=1; ARVALID handshake latches ARADDR, goes to R_ISSUE.
REQ-025 R_ISSUE (one cycle): rd=1 with rdAddr if in-range, rd=0 if out-of-range; then R_WAIT.
REQ-026 R_WAIT SHALL count RD_LATENCY cycles from the rd cycle (counter width clog2(5)), then sample rdData into RDATA (0 if out-of-range) and go to R_RESP.
REQ-027 R_RESP: RVALID=1, RRESP=2'b00/2'b10 per range, RDATA/RRESP stable until RREADY=1, then R_IDLE.
REQ-028 Out-of-range test SHALL use word index = addr >> log2(DATA/8); low byte-offset bits ignored.
REQ-029 wrAddr/rdAddr SHALL hold last value between strobes; no combinational path from any AXI input to any AXI output.

Reset
REQ-030 ARESETN=0 SHALL asynchronously force both FSMs to W_COLLECT/R_IDLE, clear held flags, counter, data registers.
REQ-031 During reset all outputs SHALL be 0, including AWREADY/WREADY/ARREADY, BVALID, RVALID, wr, rd.
REQ-032 Reset mid-transaction SHALL drop it silently; no B or R response issued after release.
REQ-033 READY outputs SHALL first assert on the first rising edge after ARESETN deasserts.

Verification
REQ-034 AW=0x08 cycle 0, W=0xDEADBEEF/WSTRB=0xF cycle 3 -> single wr with wrAddr=0x08, wrData=0xDEADBEEF, wrStrb=0xF; BVALID/BRESP=00 2 cycles after W.
REQ-035 RD_LATENCY=3, AR=0x0C, model returns 0x12345678 3 cycles after rd -> RDATA=0x12345678, RRESP=00; RREADY low 4 cycles -> RVALID and RDATA held.
REQ-036 NUM_REGS=16, write 0x40 and read 0x40 -> no wr/rd pulse; BRESP=10, RRESP=10, RDATA=0.
REQ-037 Simultaneous AW+W+AR in one cycle -> wr and rd strobes in same later cycle; both responses correct and independent.
REQ-038 Write WSTRB=0x3 to 0x04 -> wrStrb=0x3 passed unchanged; back-to-back writes with BREADY=1 complete every 3 cycles.
REQ-039 ARESETN low in R_WAIT -> outputs 0 immediately; after release no RVALID, next read completes normally.

Source files
------------

// File: rtl/axi4lite_regbus_bridge.sv
// AXI4-Lite slave to simple register-bus bridge.
// Independent write and read FSMs; strobes wr/rd are single-cycle.
module axi4lite_regbus_bridge #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 16,
  parameter int RD_LATENCY         = 1
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     wrAddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     wrData,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   wrStrb,
  output logic                              wr,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     rdAddr,
  output logic                              rd,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     rdData
);

  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int CW       = $clog2(5);
  localparam logic [31:0] LIMIT = 32'(NUM_REGS) << ADDR_LSB;

  typedef enum logic [1:0] {W_COLLECT, W_STROBE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_t;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < LIMIT;
  endfunction

  w_state_t r_wst, w_wst_nx;
  r_state_t r_rst, w_rst_nx;

  logic          r_rdy;
  logic          r_aw_held, r_w_held, r_w_err;
  logic [AW-1:0] r_awaddr;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic          r_wr;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;
  logic [SW-1:0] r_wr_strb;

  logic          r_r_err, r_rd;
  logic [AW-1:0] r_rd_addr;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_rdata;

  logic          w_aw_hs, w_w_hs, w_wgo, w_aw_in, w_ar_hs, w_ar_in;
  logic [AW-1:0] w_aw_eff;
  logic [DW-1:0] w_wd_eff;
  logic [SW-1:0] w_ws_eff;
  logic          w_lat_done;

  // Readies come only from registered state, never from AXI inputs
  assign S_AXI_AWREADY = r_rdy && (r_wst == W_COLLECT) && !r_aw_held;
  assign S_AXI_WREADY  = r_rdy && (r_wst == W_COLLECT) && !r_w_held;
  assign S_AXI_ARREADY = r_rdy && (r_rst == R_IDLE);

  assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign w_wgo    = (r_wst == W_COLLECT) &&
                    (r_aw_held || w_aw_hs) &&
                    (r_w_held || w_w_hs);
  assign w_aw_eff = r_aw_held ? r_awaddr : S_AXI_AWADDR;
  assign w_wd_eff = r_w_held ? r_wdata : S_AXI_WDATA;
  assign w_ws_eff = r_w_held ? r_wstrb : S_AXI_WSTRB;
  assign w_aw_in  = in_range(w_aw_eff);

  assign w_ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_ar_in    = in_range(S_AXI_ARADDR);
  assign w_lat_done = (r_cnt == CW'(RD_LATENCY));

  assign S_AXI_BVALID = (r_wst == W_RESP);
  assign S_AXI_BRESP  = (S_AXI_BVALID && r_w_err) ? 2'b10 : 2'b00;
  assign S_AXI_RVALID = (r_rst == R_RESP);
  assign S_AXI_RRESP  = (S_AXI_RVALID && r_r_err) ? 2'b10 : 2'b00;
  assign S_AXI_RDATA  = r_rdata;

  assign wr     = r_wr;
  assign wrAddr = r_wr_addr;
  assign wrData = r_wr_data;
  assign wrStrb = r_wr_strb;
  assign rd     = r_rd;
  assign rdAddr = r_rd_addr;

  always_comb begin
    w_wst_nx = r_wst;
    case (r_wst)
      W_COLLECT: if (w_wgo) w_wst_nx = W_STROBE;
      W_STROBE:  w_wst_nx = W_RESP;
      W_RESP:    if (S_AXI_BREADY) w_wst_nx = W_COLLECT;
      default:   w_wst_nx = W_COLLECT;
    endcase
  end

  always_comb begin
    w_rst_nx = r_rst;
    case (r_rst)
      R_IDLE:  if (w_ar_hs) w_rst_nx = R_ISSUE;
      R_ISSUE: w_rst_nx = R_WAIT;
      R_WAIT:  if (w_lat_done) w_rst_nx = R_RESP;
      R_RESP:  if (S_AXI_RREADY) w_rst_nx = R_IDLE;
      default: w_rst_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wst <= W_COLLECT;
      r_rst <= R_IDLE;
      r_rdy <= 1'b0;
    end else begin
      r_wst <= w_wst_nx;
      r_rst <= w_rst_nx;
      r_rdy <= 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_w_err   <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wr      <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_strb <= '0;
    end else begin
      r_wr      <= 1'b0;
      r_aw_held <= (r_aw_held || w_aw_hs) && !w_wgo;
      r_w_held  <= (r_w_held || w_w_hs) && !w_wgo;
      if (w_aw_hs) r_awaddr <= S_AXI_AWADDR;
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      // Bus-side outputs only move when a strobe is actually issued
      if (w_wgo) begin
        r_w_err <= !w_aw_in;
        r_wr    <= w_aw_in;
        if (w_aw_in) begin
          r_wr_addr <= w_aw_eff;
          r_wr_data <= w_wd_eff;
          r_wr_strb <= w_ws_eff;
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_r_err   <= 1'b0;
      r_rd      <= 1'b0;
      r_rd_addr <= '0;
      r_cnt     <= '0;
      r_rdata   <= '0;
    end else begin
      r_rd <= 1'b0;
      if (w_ar_hs) begin
        r_r_err <= !w_ar_in;
        r_rd    <= w_ar_in;
        if (w_ar_in) r_rd_addr <= S_AXI_ARADDR;
      end
      if (r_rst == R_ISSUE) begin
        r_cnt <= CW'(1);
      end else if (r_rst == R_WAIT) begin
        if (w_lat_done) r_rdata <= r_r_err ? '0 : rdData;
        else            r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_regbus_bridge.sv
// Scoreboard bench for axi4lite_regbus_bridge.
// Slave model answers rd after RD_LATENCY cycles and applies wr strobes.
module tb_axi4lite_regbus_bridge;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int NREG = 16;
  localparam int LAT  = 3;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } wr_exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b1;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b1;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic [SW-1:0] wrStrb;
  logic          wr;
  logic [AW-1:0] rdAddr;
  logic          rd;
  logic [DW-1:0] rdData;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  wr_exp_t       wr_q[$];
  logic [AW-1:0] rd_q[$];
  logic [1:0]    b_q[$];
  logic [33:0]   r_q[$];
  logic [DW-1:0] ref_mem [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4lite_regbus_bridge #(
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_S_AXI_DATA_WIDTH(DW),
    .NUM_REGS(NREG),
    .RD_LATENCY(LAT)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .wrAddr(wrAddr),
    .wrData(wrData),
    .wrStrb(wrStrb),
    .wr(wr),
    .rdAddr(rdAddr),
    .rd(rd),
    .rdData(rdData)
  );

  // Register-bus slave model
  logic [DW-1:0] slv_mem [64];
  logic          slv_init = 1'b0;
  logic [2:0]    p_v = '0;
  logic [AW-1:0] p_a [3];

  always @(posedge clk) begin
    p_v    <= {p_v[1:0], rd};
    p_a[0] <= rdAddr;
    p_a[1] <= p_a[0];
    p_a[2] <= p_a[1];
    if (!slv_init) begin
      for (int i = 0; i < 64; i++)
        slv_mem[i] <= (i == 3) ? 32'h1234_5678 : (32'hA500_0000 | i);
      slv_init <= 1'b1;
    end else if (wr) begin
      for (int b = 0; b < SW; b++)
        if (wrStrb[b]) slv_mem[wrAddr[7:2]][8*b+:8] <= wrData[8*b+:8];
    end
  end

  assign rdData = p_v[LAT-1] ? slv_mem[p_a[LAT-1][7:2]] : 32'hBAD0_0BAD;

  // Scoreboard monitor
  wr_exp_t       m_e;
  logic [AW-1:0] m_ra;
  logic [1:0]    m_b;
  logic [33:0]   m_r;
  logic          pb_v = 1'b0, pb_r = 1'b0, pr_v = 1'b0, pr_r = 1'b0;
  logic [1:0]    pb_resp = '0;
  logic [33:0]   pr_dat = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pb_v = 1'b0;
      pr_v = 1'b0;
    end else begin
      if (wr) begin
        n_tests++;
        if (wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: got addr=%h data=%h, required no strobe",
                   wrAddr, wrData);
        end else begin
          m_e = wr_q.pop_front();
          if ({wrAddr, wrData, wrStrb} !== {m_e.a, m_e.d, m_e.s}) begin
            n_fail++;
            $display("FAIL wr_strobe: got %h/%h/%h, required %h/%h/%h",
                     wrAddr, wrData, wrStrb, m_e.a, m_e.d, m_e.s);
          end
        end
      end
      if (rd) begin
        n_tests++;
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: got addr=%h, required no strobe", rdAddr);
        end else begin
          m_ra = rd_q.pop_front();
          if (rdAddr !== m_ra) begin
            n_fail++;
            $display("FAIL rd_addr: got %h, required %h", rdAddr, m_ra);
          end
        end
      end
      if (pb_v && !pb_r) begin
        n_tests++;
        if (bvalid !== 1'b1 || bresp !== pb_resp) begin
          n_fail++;
          $display("FAIL b_hold: got v=%b resp=%b, required v=1 resp=%b",
                   bvalid, bresp, pb_resp);
        end
      end
      if (pr_v && !pr_r) begin
        n_tests++;
        if (rvalid !== 1'b1 || {rresp, rdata} !== pr_dat) begin
          n_fail++;
          $display("FAIL r_hold: got v=%b %h, required v=1 %h",
                   rvalid, {rresp, rdata}, pr_dat);
        end
      end
      if (bvalid && bready) begin
        n_tests++;
        if (b_q.size() == 0) begin
          n_fail++;
          $display("FAIL b_unexpected: got resp=%b, required no response", bresp);
        end else begin
          m_b = b_q.pop_front();
          if (bresp !== m_b) begin
            n_fail++;
            $display("FAIL bresp: got %b, required %b", bresp, m_b);
          end
        end
      end
      if (rvalid && rready) begin
        n_tests++;
        if (r_q.size() == 0) begin
          n_fail++;
          $display("FAIL r_unexpected: got %h, required no response", {rresp, rdata});
        end else begin
          m_r = r_q.pop_front();
          if ({rresp, rdata} !== m_r) begin
            n_fail++;
            $display("FAIL rresp_rdata: got %h, required %h", {rresp, rdata}, m_r);
          end
        end
      end
      pb_v = bvalid; pb_r = bready; pb_resp = bresp;
      pr_v = rvalid; pr_r = rready; pr_dat = {rresp, rdata};
    end
  end

  function automatic logic in_rng(input logic [AW-1:0] a);
    return (int'(a) >> 2) < NREG;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [AW-1:0] a);
    awaddr  = a;
    awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready) begin
        tick();
        awvalid = 1'b0;
        return;
      end
      tick();
    end
    awvalid = 1'b0;
    n_tests++; n_fail++;
    $display("FAIL aw_timeout: got no AWREADY, required handshake");
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s);
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wready) begin
        tick();
        wvalid = 1'b0;
        return;
      end
      tick();
    end
    wvalid = 1'b0;
    n_tests++; n_fail++;
    $display("FAIL w_timeout: got no WREADY, required handshake");
  endtask

  task automatic ar_send(input logic [AW-1:0] a);
    araddr  = a;
    arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin
        tick();
        arvalid = 1'b0;
        return;
      end
      tick();
    end
    arvalid = 1'b0;
    n_tests++; n_fail++;
    $display("FAIL ar_timeout: got no ARREADY, required handshake");
  endtask

  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s);
    if (in_rng(a)) begin
      wr_q.push_back('{a, d, s});
      for (int b = 0; b < SW; b++)
        if (s[b]) ref_mem[a[7:2]][8*b+:8] = d[8*b+:8];
      b_q.push_back(2'b00);
    end else begin
      b_q.push_back(2'b10);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input int awd, input int wd);
    push_write(a, d, s);
    fork
      begin repeat (awd) tick(); aw_send(a); end
      begin repeat (wd) tick(); w_send(d, s); end
    join
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int dly);
    if (in_rng(a)) begin
      rd_q.push_back(a);
      r_q.push_back({2'b00, ref_mem[a[7:2]]});
    end else begin
      r_q.push_back({2'b10, 32'h0});
    end
    repeat (dly) tick();
    ar_send(a);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (wr_q.size() == 0 && rd_q.size() == 0 &&
          b_q.size() == 0 && r_q.size() == 0) return;
      tick();
    end
    n_tests++; n_fail++;
    $display("FAIL idle_timeout: got %0d/%0d/%0d/%0d pending, required 0",
             wr_q.size(), rd_q.size(), b_q.size(), r_q.size());
    wr_q.delete(); rd_q.delete(); b_q.delete(); r_q.delete();
  endtask

  task automatic check_outputs_zero(input string nm);
    n_tests++;
    if ({awready, wready, arready, bvalid, rvalid, wr, rd, bresp, rresp,
         rdata, wrAddr, wrData, wrStrb, rdAddr} !== '0) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b%b%b bv=%b rv=%b wr=%b rd=%b rdata=%h, required all 0",
               nm, awready, wready, arready, bvalid, rvalid, wr, rd, rdata);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    check_outputs_zero("reset_outputs");
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    n_tests++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b, required 000", {awready, wready, arready});
    end
    tick();
    n_tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL ready_after_edge: got %b, required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_write_split();
    push_write(8'h08, 32'hDEAD_BEEF, 4'hF);
    aw_send(8'h08);
    n_tests++;
    if ({awready, wready} !== 2'b01) begin
      n_fail++;
      $display("FAIL aw_held_ready: got %b, required 01", {awready, wready});
    end
    repeat (2) tick();
    w_send(32'hDEAD_BEEF, 4'hF);
    n_tests++;
    if ({wr, bvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL w_strobe_cycle: got wr,bv=%b, required 10", {wr, bvalid});
    end
    tick();
    n_tests++;
    if ({wr, bvalid, bresp} !== 4'b0100) begin
      n_fail++;
      $display("FAIL bvalid_timing: got wr,bv,resp=%b, required 0100", {wr, bvalid, bresp});
    end
    wait_idle();
  endtask

  task automatic test_read_hold();
    rready = 1'b0;
    do_read(8'h0C, 0);
    n_tests++;
    if (rd !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_issue: got %b, required 1", rd);
    end
    repeat (3) tick();
    n_tests++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rvalid_early: got %b, required 0", rvalid);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'h1234_5678}) begin
        n_fail++;
        $display("FAIL r_stall_%0d: got v=%b resp=%b data=%h, required 1/00/12345678",
                 i, rvalid, rresp, rdata);
      end
      if (i < 4) tick();
    end
    rready = 1'b1;
    wait_idle();
  endtask

  task automatic test_out_of_range();
    do_write(8'h40, 32'h5555_AAAA, 4'hF, 0, 0);
    wait_idle();
    do_read(8'h40, 0);
    wait_idle();
    do_write(8'h43, 32'h1111_2222, 4'hF, 1, 0);
    wait_idle();
    do_write(8'h3C, 32'hCAFE_F00D, 4'hF, 0, 2);
    wait_idle();
    do_read(8'h3C, 0);
    wait_idle();
    do_read(8'h3F, 1);
    wait_idle();
    do_read(8'h7C, 0);
    wait_idle();
  endtask

  task automatic test_simultaneous();
    fork
      do_write(8'h10, 32'h0BAD_F00D, 4'hF, 0, 0);
      do_read(8'h14, 0);
    join
    n_tests++;
    if ({wr, rd} !== 2'b11) begin
      n_fail++;
      $display("FAIL wr_rd_same_cycle: got %b, required 11", {wr, rd});
    end
    wait_idle();
  endtask

  task automatic test_strobe_b2b();
    int t_prev;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic hs;
    do_write(8'h04, 32'h1122_3344, 4'h3, 0, 0);
    wait_idle();
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      a = AW'(8'h20 + 4 * k);
      d = $urandom;
      push_write(a, d, 4'hF);
      awaddr = a; awvalid = 1'b1;
      wdata = d; wstrb = 4'hF; wvalid = 1'b1;
      hs = 1'b0;
      for (int i = 0; i < 20 && !hs; i++) begin
        @(negedge clk);
        hs = awready && wready;
        tick();
      end
      if (!hs) begin
        n_tests++; n_fail++;
        $display("FAIL b2b_timeout_%0d: got no handshake, required one", k);
      end
      if (k > 0) begin
        n_tests++;
        if (cyc - t_prev != 3) begin
          n_fail++;
          $display("FAIL b2b_period_%0d: got %0d cycles, required 3", k, cyc - t_prev);
        end
      end
      t_prev = cyc;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wait_idle();
    do_read(8'h04, 0);
    wait_idle();
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 10; i++) begin
      a = AW'($urandom_range(0, 79)) & 8'hFC;
      do_write(a, $urandom, SW'($urandom_range(1, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3));
      wait_idle();
      do_read(a, $urandom_range(0, 2));
      wait_idle();
    end
  endtask

  task automatic test_reset_midread();
    logic seen;
    do_read(8'h08, 0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_in_r_wait");
    r_q.delete();
    rd_q.delete();
    repeat (2) tick();
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | rvalid | bvalid;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_response: got a response after reset, required none");
    end
    do_read(8'h0C, 0);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++)
      ref_mem[i] = (i == 3) ? 32'h1234_5678 : (32'hA500_0000 | i);
    test_reset();
    test_write_split();
    test_read_hold();
    test_out_of_range();
    test_simultaneous();
    test_strobe_b2b();
    test_random();
    test_reset_midread();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
